// File: rtl/shift_left_logical_seq.sv
// Purpose: multi-cycle logical left shifter, one binary-weighted stage (16,8,4,2,1) per clock.
// Latency: result valid S+1 cycles after accept (SHIFT_LEFT_EARLY_DONE_EN: stops after lowest set shamt bit).
// Backpressure: result held in DONE until out_ready; no new operand accepted until back in IDLE.
module shift_left_logical_seq #(
    parameter int N = 32,
    parameter int S = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic [S-1:0] in_shamt,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         busy
);

    localparam int SW = $clog2(S);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [N-1:0]  data_r;
    logic [S-1:0]  amt_r;
    logic [SW-1:0] stage;
    logic [N-1:0]  stage_shifted;
    logic          last_stage;

    // Stage counter walks from the 16-bit stage down to the 1-bit stage.
    assign last_stage = (stage == '0);

`ifdef SHIFT_LEFT_EARLY_DONE_EN
    // Bits of amt_r below the current stage; once they are all zero no later stage moves data.
    logic [S-1:0] low_mask;
    logic         low_zero;
    assign low_mask = (S'(1) << stage) - S'(1);
    assign low_zero = ((amt_r & low_mask) == '0);
`endif

    // Barrel stage selected by the counter: shift by 1<<stage, zero fill at the LSB end.
    always_comb begin
        stage_shifted = data_r;
        case (stage)
            SW'(4):  stage_shifted = {data_r[N-17:0], 16'b0};
            SW'(3):  stage_shifted = {data_r[N-9:0],  8'b0};
            SW'(2):  stage_shifted = {data_r[N-5:0],  4'b0};
            SW'(1):  stage_shifted = {data_r[N-3:0],  2'b0};
            SW'(0):  stage_shifted = {data_r[N-2:0],  1'b0};
            default: stage_shifted = data_r;
        endcase
    end

    // State register; an asynchronous reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: accept in IDLE, step through stages in SHIFT, wait for consumer in DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
`ifdef SHIFT_LEFT_EARLY_DONE_EN
                    state_nxt = (in_shamt == '0) ? ST_DONE : ST_SHIFT;
`else
                    state_nxt = ST_SHIFT;
`endif
                end
            end
            ST_SHIFT: begin
`ifdef SHIFT_LEFT_EARLY_DONE_EN
                if (last_stage || low_zero) begin
                    state_nxt = ST_DONE;
                end
`else
                if (last_stage) begin
                    state_nxt = ST_DONE;
                end
`endif
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Handshake and status outputs decoded purely from state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
            end
            ST_SHIFT: begin
                busy = 1'b1;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // Datapath: capture operand on accept, apply one stage per SHIFT cycle, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r <= '0;
            amt_r  <= '0;
            stage  <= SW'(S - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        data_r <= in_data;
                        amt_r  <= in_shamt;
                        stage  <= SW'(S - 1);
                    end
                end
                ST_SHIFT: begin
                    if (amt_r[stage]) begin
                        data_r <= stage_shifted;
                    end
                    if (state_nxt == ST_SHIFT) begin
                        stage <= stage - 1'b1;
                    end
                end
                default: begin
                    data_r <= data_r;
                end
            endcase
        end
    end

    // Result is the working register itself; it cannot change while DONE waits.
    assign out_data = data_r;

endmodule

// File: tb/tb_shift_left_logical_seq.sv
module tb_shift_left_logical_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    int tests = 0;
    int fails = 0;

    shift_left_logical_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  shamt;
        logic [31:0] exp;
        int          stall;
        bit          noise;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference result: plain arithmetic left shift truncated to 32 bits.
    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] sh);
        logic [63:0] wide;
        wide = {32'b0, d} << sh;
        return wide[31:0];
    endfunction

    // Reference latency (cycle of first out_valid, accept cycle = 0).
    function automatic int ref_lat(input logic [4:0] sh);
`ifdef SHIFT_LEFT_EARLY_DONE_EN
        int low;
        if (sh == 0) return 1;
        low = 0;
        while (((sh >> low) & 5'd1) == 5'd0) low++;
        return 1 + (5 - low);
`else
        return 6;
`endif
    endfunction

    // Called at a negedge in IDLE. Drives one operand, measures latency, checks result,
    // optionally stalls the consumer and injects ignored traffic on the input side.
    task automatic run_op(input logic [31:0] d, input logic [4:0] sh, input logic [31:0] exp,
                          input int stall, input bit noise);
        int cyc;
        int bad;
        logic [31:0] held;
        check("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        in_data   = d;
        in_shamt  = sh;
        out_ready = (stall == 0);
        @(posedge clk);
        @(negedge clk);
        cyc = 1;
        bad = 0;
        if (noise) begin
            in_data  = $urandom;
            in_shamt = 5'($urandom_range(0, 31));
        end else begin
            in_valid = 1'b0;
        end
        while (!out_valid && cyc < 20) begin
            if (in_ready !== 1'b0 || busy !== 1'b1) bad++;
            @(negedge clk);
            cyc++;
            if (noise) begin
                in_data  = $urandom;
                in_shamt = 5'($urandom_range(0, 31));
            end
        end
        check("latency", 32'(cyc), 32'(ref_lat(sh)));
        check("out_data", out_data, exp);
        check("busy_not_ready_in_flight", 32'(bad), 32'd0);
        if (stall > 0) begin
            held = out_data;
            bad  = 0;
            repeat (stall) begin
                if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 || out_data !== held) bad++;
                in_valid = 1'b1;
                in_data  = $urandom;
                @(negedge clk);
            end
            check("stall_hold", 32'(bad), 32'd0);
            check("stall_data", out_data, exp);
            out_ready = 1'b1;
            @(negedge clk);
        end else begin
            @(negedge clk);
        end
        // Handshake edge has passed with in_valid possibly high: must be IDLE, nothing accepted.
        check("idle_after_handshake", {29'b0, in_ready, out_valid, busy}, 32'b100);
        in_valid = 1'b0;
    endtask

    vec_t vecs[6];

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        out_ready = 1'b0;

        vecs[0] = '{32'h0000_0001, 5'd31, 32'h8000_0000, 0,  1'b0};
        vecs[1] = '{32'hDEAD_BEEF, 5'd4,  32'hEADB_EEF0, 0,  1'b0};
        vecs[2] = '{32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 0,  1'b0};
        vecs[3] = '{32'h0000_000F, 5'd8,  32'h0000_0F00, 10, 1'b0};
        vecs[4] = '{32'hFFFF_FFFF, 5'd16, 32'hFFFF_0000, 0,  1'b1};
        vecs[5] = '{32'h8000_0001, 5'd1,  32'h0000_0002, 3,  1'b1};

        // Reset values take effect without any clock edge.
        #1;
        check("reset_flags", {29'b0, in_ready, out_valid, busy}, 32'b100);
        check("reset_out_data", out_data, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].data, vecs[i].shamt, vecs[i].exp, vecs[i].stall, vecs[i].noise);
        end

        // All-ones shamt sweep against the reference model.
        for (int s = 0; s < 32; s++) begin
            run_op(32'hFFFF_FFFF, 5'(s), ref_shift(32'hFFFF_FFFF, 5'(s)), 0, 1'b0);
        end

        // Randomized operands, shift amounts, stalls and input noise.
        for (int r = 0; r < 40; r++) begin
            logic [31:0] d;
            logic [4:0]  sh;
            d  = $urandom;
            sh = 5'($urandom_range(0, 31));
            run_op(d, sh, ref_shift(d, sh), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
        end

        // Mid-operation asynchronous reset between clock edges.
        in_valid = 1'b1;
        in_data  = 32'hFFFF_FFFF;
        in_shamt = 5'd3;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midop_reset_flags", {29'b0, in_ready, out_valid, busy}, 32'b100);
        check("midop_reset_data", out_data, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("midop_reset_hold", {29'b0, in_ready, out_valid, busy}, 32'b100);
        rst_n = 1'b1;
        @(negedge clk);
        check("after_reset_no_result", {31'b0, out_valid}, 32'd0);
        run_op(32'h1234_5678, 5'd12, 32'h4567_8000, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
